// File: rtl/time_decoder.sv
// Keypad-side timer: shifts keyed BCD digits into an M:SS register in load mode
// and counts it down once per synchronized 1 Hz tick in count mode.
module time_decoder #(
    parameter int unsigned SEC_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       enablen,
    input  logic [3:0] bcd_input,
    input  logic       loadn,
    input  logic       pgt_1hz,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       running,
    output logic       done
);

    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COUNT   = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          pgt_s1;
    logic          pgt_s2;
    logic          pgt_s3;
    logic          loadn_s1;
    logic          loadn_s2;
    logic [DW-1:0] bcd_s1;
    logic [DW-1:0] bcd_s2;
    logic          tick;
    logic [DW-1:0] dec_m;
    logic [DW-1:0] dec_t;
    logic [DW-1:0] dec_o;
    logic [DW-1:0] m_nxt;
    logic [DW-1:0] t_nxt;
    logic [DW-1:0] o_nxt;
    logic          done_nxt;

    // Two-flop synchronizers; pgt s3 resets high so a level held through reset is not an edge
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            pgt_s1   <= 1'b0;
            pgt_s2   <= 1'b0;
            pgt_s3   <= 1'b1;
            loadn_s1 <= 1'b1;
            loadn_s2 <= 1'b1;
            bcd_s1   <= '0;
            bcd_s2   <= '0;
        end else begin
            pgt_s1   <= pgt_1hz;
            pgt_s2   <= pgt_s1;
            pgt_s3   <= pgt_s2;
            loadn_s1 <= loadn;
            loadn_s2 <= loadn_s1;
            bcd_s1   <= bcd_input;
            bcd_s2   <= bcd_s1;
        end
    end

    assign tick    = pgt_s2 & ~pgt_s3;
    assign zero    = (min_ones == '0) && (sec_tens == '0) && (sec_ones == '0);
    assign running = (state == S_COUNT);

    // Digit-wise BCD decrement; tens above 5 are not normalized
    always_comb begin
        dec_m = min_ones;
        dec_t = sec_tens;
        dec_o = sec_ones;
        if (sec_ones != '0) begin
            dec_o = sec_ones - DW'(1);
        end else begin
            dec_o = DW'(9);
            if (sec_tens != '0) begin
                dec_t = sec_tens - DW'(1);
            end else begin
                dec_t = DW'(SEC_TENS_MAX);
                dec_m = min_ones - DW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = min_ones;
        t_nxt     = sec_tens;
        o_nxt     = sec_ones;
        done_nxt  = 1'b0;
        case (state)
            S_LOAD: begin
                if (!enablen) begin
                    state_nxt = S_COUNT;
                end else if (tick && !loadn_s2 && (bcd_s2 <= DW'(9))) begin
                    m_nxt = sec_tens;
                    t_nxt = sec_ones;
                    o_nxt = bcd_s2;
                end
            end
            S_COUNT: begin
                if (enablen) begin
                    state_nxt = S_LOAD;
                end else if (zero) begin
                    state_nxt = S_EXPIRED;
                end else if (tick) begin
                    m_nxt = dec_m;
                    t_nxt = dec_t;
                    o_nxt = dec_o;
                    if ((dec_m == '0) && (dec_t == '0) && (dec_o == '0)) begin
                        state_nxt = S_EXPIRED;
                        done_nxt  = 1'b1;
                    end
                end
            end
            S_EXPIRED: begin
                if (enablen) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state    <= S_LOAD;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            min_ones <= m_nxt;
            sec_tens <= t_nxt;
            sec_ones <= o_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: doc/time_decoder.md
# time_decoder

Receiving end of the keypad encoder interface. It consumes the encoder's BCD digit, `loadn` key strobe and `pgt_1hz` pulse train. In load mode it shifts keyed digits into a three-digit M:SS register. In count mode it decrements that register once per `pgt_1hz` rising edge and reports expiry. It sits between the keypad encoder and the display driver / oven control FSM.

## Interface
- `SEC_TENS_MAX`, default 5: value loaded into `sec_tens` on a borrow from `sec_ones`.
- `clk`  in  1  system clock; all state changes on rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `enablen`  in  1  mode select, synchronous to `clk`. 1 = load mode, 0 = count mode. Also drives the encoder's mux.
- `bcd_input`  in  4  BCD digit from the encoder; codes 10–15 are invalid.
- `loadn`  in  1  active-low key-held level from the encoder.
- `pgt_1hz`  in  1  strobe/tick from the encoder: key-debounce pulse in load mode, 1 Hz in count mode.
- `min_ones`  out  4  minutes digit, BCD.
- `sec_tens`  out  4  tens-of-seconds digit, BCD.
- `sec_ones`  out  4  seconds digit, BCD.
- `zero`  out  1  high when all three digits are 0 (combinational decode of the digit registers).
- `running`  out  1  high while the state is COUNT.
- `done`  out  1  one-clk pulse when a count reaches 0:00.

## Operation
**Input synchronization**
- `pgt_1hz`, `loadn` and `bcd_input` each pass through 2 flops (s1, s2).
- `pgt_1hz` has a third flop, s3. `tick = s2 & ~s3`.
- Reset values: `pgt_1hz` s1/s2 = 0, s3 = 1. `loadn` sync = 1. `bcd_input` sync = 0.
- Because s3 resets to 1, `pgt_1hz` held high at reset release produces no tick.

**State machine: LOAD, COUNT, EXPIRED** (reset state LOAD)
- LOAD: on `tick` with synced `loadn` = 0 and synced digit ≤ 9:
  - shift left: `min_ones` ← `sec_tens`, `sec_tens` ← `sec_ones`, `sec_ones` ← digit;
  - the old `min_ones` is discarded;
  - digits 10–15 are ignored, with no shift.
  - `enablen` = 0 → COUNT.
- COUNT:
  - `enablen` = 1 → LOAD. This is a pause: digits are held and the tick is ignored.
  - else if `zero` → EXPIRED. No `done` pulse; this covers starting with 0:00.
  - else on `tick`: decrement; if the result is 0:00 → EXPIRED with `done` = 1 for that one cycle.
  - `loadn` and `bcd_input` are ignored in COUNT.
- EXPIRED: digits are held and ticks and keys are ignored. `enablen` = 1 → LOAD.

**Decrement (BCD with borrow)**
- `sec_ones` > 0: `sec_ones` − 1.
- Otherwise `sec_ones` ← 9 and borrow:
  - `sec_tens` > 0: `sec_tens` − 1;
  - otherwise `sec_tens` ← `SEC_TENS_MAX` and `min_ones` − 1.
- Entered values with `sec_tens` > 5 (e.g. 1:75) are not normalized; they count down digit-wise (1:75 → 1:74 … 1:00 → 0:59).
- 0:00 is never decremented (guarded by `zero`).

## Timing
- Latency: if `pgt_1hz` is first sampled high at clk edge N, the digit registers and `done` update at edge N+2. `loadn` and `bcd_input` must be stable from edge N−1 through N+1.
- The action taken is selected by the current state register. The transition and its action happen on the same edge.
- If `enablen` rises on the same edge that a tick is processed in COUNT, the machine goes to LOAD with no decrement.
- `done` is registered. Reset value of every output: digits 0, `zero` = 1, `running` = 0, `done` = 0.
- `clear` mid-count: immediate asynchronous return to LOAD with all digits 0. No `done` is emitted.
- Ticks closer than 3 clk cycles apart may merge; the encoder guarantees much wider spacing.

## Test plan
- Reset with `pgt_1hz` = 1 → after release there is no tick, digits stay 0:00, `zero` = 1, `running` = 0.
- LOAD mode, keys 1, 2, 5, 7, each a `loadn` = 0 + `pgt_1hz` pulse → digits 0:01, 0:12, 1:25, then 2:57. Key code 12 → no change.
- Load 0:03, set `enablen` = 0, send 3 ticks → 0:02, 0:01, 0:00. `done` is high exactly 1 cycle at edge N+2 of the third tick. State goes to EXPIRED and further ticks change nothing.
- Load 1:00, count one tick → 0:59. With `SEC_TENS_MAX` = 9 the same stimulus gives 0:99.
- Count from 0:05, after 2 ticks raise `enablen` → digits held at 0:03, `running` = 0. Lower `enablen` → count resumes to 0:02.
- Enter count mode with 0:00 → EXPIRED next cycle, `done` never asserted. Assert `clear` mid-count at 0:40 → all digits 0, LOAD state.
